// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown timer sequencing controller:
// FSM state encodings, BCD digit constant, enable levels, default tick period.
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_ZERO            = 4'h0;
    localparam logic        ENABLED             = 1'b1;
    localparam logic        DISABLED            = 1'b0;
    localparam int unsigned DEFAULT_TICK_CYCLES = 100000000;

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler for the countdown timer: divides clk down to a single-cycle tick
// every TICK_CYCLES cycles while run is high; holds while run is low; clr
// forces the count back to zero and takes priority over run.
module tick_gen
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int unsigned PRE_W       = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    logic [PRE_W-1:0] prescaler;
    logic             terminal;

    assign terminal = (prescaler == PRE_LAST);
    assign tick     = run & terminal;

    // Prescaler: clear, wrap at terminal count, or hold when not running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (clr) begin
            prescaler <= '0;
        end else if (run) begin
            if (terminal) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the MM:SS BCD down-counter chain.
// Start/pause/clear/done FSM, expiry detect on the chain value, and
// registered enable / decrement / reload strobes plus alarm.
// Optional feature macro: COUNTDOWN_ALARM_BLINK_EN (alarm blinks in DONE).
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int unsigned PRE_W       = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   cnt_value,
    output logic                  cnt_en,
    output logic                  cnt_dec,
    output logic                  cnt_load,
    output logic                  alarm,
    output logic [1:0]            state
);

    state_t state_q;
    logic   zero;
    logic   tick;
    logic   pre_run;
    logic   pre_clr;

    assign zero  = (cnt_value == {DIGITS{BCD_ZERO}});
    assign state = state_q;

    // Prescaler control: which states count, and every path that re-zeroes it
    always_comb begin
        pre_run = (state_q == ST_RUN);
        pre_clr = clear
                | (state_q == ST_IDLE)
                | ((state_q == ST_DONE) & start_stop);
`ifdef COUNTDOWN_ALARM_BLINK_EN
        pre_run = pre_run | (state_q == ST_DONE);
`else
        // Without blinking the prescaler sits at zero from DONE entry onward
        pre_clr = pre_clr
                | ((state_q == ST_RUN) & zero)
                | (state_q == ST_DONE);
`endif
    end

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES),
        .PRE_W       (PRE_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (pre_run),
        .clr   (pre_clr),
        .tick  (tick)
    );

    // Controller FSM with registered strobes, enable and alarm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_en   <= DISABLED;
            cnt_dec  <= 1'b0;
            cnt_load <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            cnt_dec  <= 1'b0;
            cnt_load <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        cnt_load <= 1'b1;
                    end else if (start_stop && !zero) begin
                        state_q <= ST_RUN;
                        cnt_en  <= ENABLED;
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q  <= ST_IDLE;
                        cnt_en   <= DISABLED;
                        cnt_load <= 1'b1;
                    end else if (zero) begin
                        // Expiry beats a pending tick so the chain never wraps
                        state_q <= ST_DONE;
                        alarm   <= 1'b1;
                    end else begin
                        if (tick) begin
                            cnt_dec <= 1'b1;
                        end
                        if (start_stop) begin
                            state_q <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clear) begin
                        state_q  <= ST_IDLE;
                        cnt_en   <= DISABLED;
                        cnt_load <= 1'b1;
                    end else if (start_stop) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (clear || start_stop) begin
                        state_q  <= ST_IDLE;
                        cnt_en   <= DISABLED;
                        cnt_load <= 1'b1;
                        alarm    <= 1'b0;
                    end else begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
                        if (tick) begin
                            alarm <= ~alarm;
                        end
`else
                        alarm <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_en  <= DISABLED;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule
